// File: rtl/udp_rx_parser.sv
// Receive-side Ethernet II / IPv4 / UDP parser: filters on local MAC/IP/port and streams UDP payload.
// Optional FCS verification is built when UDP_RX_CRC_CHECK_EN is defined.
module udp_rx_parser #(
    parameter logic [47:0] LOCAL_MAC  = 48'h06_00_AA_BB_0C_DD,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0F0F,
    parameter logic [15:0] LOCAL_PORT = 16'd8080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_rx_dv,
    input  logic        i_rx_de,
    input  logic [7:0]  i_rx_data,
    output logic        o_data_de,
    output logic [7:0]  o_data,
    output logic [15:0] o_data_len,
    output logic [31:0] o_src_ip,
    output logic [15:0] o_src_port,
    output logic        o_pkt_done,
    output logic        o_pkt_ok,
    output logic        o_busy
);

    localparam int unsigned CNT_W = 11;

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_ETH_HDR, S_IP_HDR, S_UDP_HDR, S_PAYLOAD, S_TAIL, S_DROP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mac_loc_q, mac_loc_d, mac_bc_q, mac_bc_d;
    logic               accepted_q, accepted_d, bad_q, bad_d;
    logic [31:0]        ip_sh_q, ip_sh_d;
    logic [15:0]        port_sh_q, port_sh_d, udp_len_q, udp_len_d;
    logic               data_de_q, data_de_d, done_q, done_d, ok_q, ok_d, busy_q, busy_d;
    logic [7:0]         data_q, data_d;
    logic [15:0]        data_len_q, data_len_d, src_port_q, src_port_d;
    logic [31:0]        src_ip_q, src_ip_d;
    logic               byte_v, crc_ok_c;
    logic [2:0]         mac_sel;
    logic [1:0]         ip_sel;
    logic [7:0]         mac_exp, ip_exp, port_exp;

    assign byte_v   = i_rx_dv & i_rx_de;
    assign mac_sel  = 3'd5 - cnt_q[2:0];
    assign ip_sel   = 2'd3 - cnt_q[1:0];
    assign mac_exp  = 8'(LOCAL_MAC >> {mac_sel, 3'b000});
    assign ip_exp   = 8'(LOCAL_IP >> {ip_sel, 3'b000});
    assign port_exp = cnt_q[0] ? LOCAL_PORT[7:0] : LOCAL_PORT[15:8];

`ifdef UDP_RX_CRC_CHECK_EN
    logic [31:0] crc_q, crc_d;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    // CRC spans destination MAC through the last FCS byte; the residue check needs no extra cycle.
    always_comb begin
        crc_d = crc_q;
        if (byte_v) begin
            if (state_q == S_PREAMBLE && i_rx_data == 8'hD5) crc_d = 32'hFFFF_FFFF;
            else if (state_q inside {S_ETH_HDR, S_IP_HDR, S_UDP_HDR, S_PAYLOAD, S_TAIL})
                crc_d = crc32_byte(crc_q, i_rx_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_q <= '0;
        else        crc_q <= crc_d;
    end

    assign crc_ok_c = (crc_q == 32'hDEBB_20E3);
`else
    assign crc_ok_c = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state; a byte outside IDLE's 55 start sends the rest of the frame to DROP.
    always_comb begin
        state_d = state_q;
        if (!i_rx_dv) begin
            state_d = S_IDLE;
        end else if (byte_v) begin
            case (state_q)
                S_IDLE:     state_d = (i_rx_data == 8'h55) ? S_PREAMBLE : S_DROP;
                S_PREAMBLE: begin
                    if (i_rx_data == 8'hD5)      state_d = S_ETH_HDR;
                    else if (i_rx_data != 8'h55) state_d = S_DROP;
                end
                S_ETH_HDR: begin
                    if (cnt_q == 11'd5 && !(mac_loc_d || mac_bc_d))   state_d = S_DROP;
                    else if (cnt_q == 11'd12 && i_rx_data != 8'h08)   state_d = S_DROP;
                    else if (cnt_q == 11'd13)
                        state_d = (i_rx_data == 8'h00) ? S_IP_HDR : S_DROP;
                end
                S_IP_HDR: begin
                    if (cnt_q == 11'd0 && i_rx_data != 8'h45)         state_d = S_DROP;
                    else if (cnt_q == 11'd9 && i_rx_data != 8'h11)    state_d = S_DROP;
                    else if (cnt_q >= 11'd16 && i_rx_data != ip_exp)  state_d = S_DROP;
                    else if (cnt_q == 11'd19)                         state_d = S_UDP_HDR;
                end
                S_UDP_HDR: begin
                    if ((cnt_q == 11'd2 || cnt_q == 11'd3) && i_rx_data != port_exp) state_d = S_DROP;
                    else if (cnt_q == 11'd7)
                        state_d = (udp_len_q <= 16'd8) ? S_TAIL : S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    if (16'(cnt_q) == data_len_q - 16'd1) state_d = S_TAIL;
                end
                default: state_d = state_q;
            endcase
        end
        cnt_d = (state_d != state_q) ? '0 : (byte_v ? cnt_q + 11'd1 : cnt_q);
    end

    // Field capture, acceptance bookkeeping and output staging.
    always_comb begin
        mac_loc_d  = mac_loc_q;
        mac_bc_d   = mac_bc_q;
        accepted_d = accepted_q;
        bad_d      = bad_q;
        ip_sh_d    = ip_sh_q;
        port_sh_d  = port_sh_q;
        udp_len_d  = udp_len_q;
        data_len_d = data_len_q;
        src_ip_d   = src_ip_q;
        src_port_d = src_port_q;
        data_d     = data_q;
        data_de_d  = 1'b0;
        done_d     = 1'b0;
        ok_d       = 1'b0;
        busy_d     = (state_d != S_IDLE);
        if (!i_rx_dv) begin
            if (state_q != S_IDLE) begin
                done_d = accepted_q;
                ok_d   = accepted_q && (state_q == S_TAIL) && !bad_q && crc_ok_c;
            end
            accepted_d = 1'b0;
            bad_d      = 1'b0;
        end else if (byte_v) begin
            case (state_q)
                S_PREAMBLE: begin
                    if (i_rx_data == 8'hD5) begin
                        mac_loc_d  = 1'b1;
                        mac_bc_d   = 1'b1;
                        accepted_d = 1'b0;
                        bad_d      = 1'b0;
                    end
                end
                S_ETH_HDR: begin
                    if (cnt_q < 11'd6) begin
                        mac_loc_d = mac_loc_q && (i_rx_data == mac_exp);
                        mac_bc_d  = mac_bc_q && (i_rx_data == 8'hFF);
                    end
                end
                S_IP_HDR: begin
                    if (cnt_q >= 11'd12 && cnt_q <= 11'd15) ip_sh_d = {ip_sh_q[23:0], i_rx_data};
                end
                S_UDP_HDR: begin
                    if (cnt_q <= 11'd1) port_sh_d = {port_sh_q[7:0], i_rx_data};
                    if (cnt_q == 11'd3 && i_rx_data == port_exp) begin
                        accepted_d = 1'b1;
                        src_ip_d   = ip_sh_q;
                        src_port_d = port_sh_q;
                    end
                    if (cnt_q == 11'd4 || cnt_q == 11'd5) udp_len_d = {udp_len_q[7:0], i_rx_data};
                    if (cnt_q == 11'd7) begin
                        bad_d      = (udp_len_q < 16'd8);
                        data_len_d = (udp_len_q < 16'd8) ? 16'd0 : udp_len_q - 16'd8;
                    end
                end
                S_PAYLOAD: begin
                    data_de_d = 1'b1;
                    data_d    = i_rx_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            mac_loc_q  <= 1'b0;
            mac_bc_q   <= 1'b0;
            accepted_q <= 1'b0;
            bad_q      <= 1'b0;
            ip_sh_q    <= '0;
            port_sh_q  <= '0;
            udp_len_q  <= '0;
            data_len_q <= '0;
            src_ip_q   <= '0;
            src_port_q <= '0;
            data_q     <= '0;
            data_de_q  <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            mac_loc_q  <= mac_loc_d;
            mac_bc_q   <= mac_bc_d;
            accepted_q <= accepted_d;
            bad_q      <= bad_d;
            ip_sh_q    <= ip_sh_d;
            port_sh_q  <= port_sh_d;
            udp_len_q  <= udp_len_d;
            data_len_q <= data_len_d;
            src_ip_q   <= src_ip_d;
            src_port_q <= src_port_d;
            data_q     <= data_d;
            data_de_q  <= data_de_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            busy_q     <= busy_d;
        end
    end

    assign o_data_de  = data_de_q;
    assign o_data     = data_q;
    assign o_data_len = data_len_q;
    assign o_src_ip   = src_ip_q;
    assign o_src_port = src_port_q;
    assign o_pkt_done = done_q;
    assign o_pkt_ok   = ok_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_udp_rx_parser.sv
// Bench for udp_rx_parser: table of frame vectors plus back-to-back and mid-frame reset sequences.
// Expected o_pkt_ok for the corrupted-payload vector depends on UDP_RX_CRC_CHECK_EN.
module tb_udp_rx_parser;

    localparam logic [47:0] LOCAL_MAC  = 48'h06_00_AA_BB_0C_DD;
    localparam logic [31:0] LOCAL_IP   = 32'hC0A8_0F0F;
    localparam logic [15:0] LOCAL_PORT = 16'd8080;
`ifdef UDP_RX_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif
    localparam int NV = 11;

    logic        clk = 1'b0;
    logic        rst_n, i_rx_dv, i_rx_de;
    logic [7:0]  i_rx_data;
    logic        o_data_de, o_pkt_done, o_pkt_ok, o_busy;
    logic [7:0]  o_data;
    logic [15:0] o_data_len, o_src_port;
    logic [31:0] o_src_ip;

    always #5 clk = ~clk;

    udp_rx_parser #(.LOCAL_MAC(LOCAL_MAC), .LOCAL_IP(LOCAL_IP), .LOCAL_PORT(LOCAL_PORT)) dut (
        .clk(clk), .rst_n(rst_n), .i_rx_dv(i_rx_dv), .i_rx_de(i_rx_de), .i_rx_data(i_rx_data),
        .o_data_de(o_data_de), .o_data(o_data), .o_data_len(o_data_len), .o_src_ip(o_src_ip),
        .o_src_port(o_src_port), .o_pkt_done(o_pkt_done), .o_pkt_ok(o_pkt_ok), .o_busy(o_busy)
    );

    typedef struct {
        logic [47:0] mac;
        logic [15:0] etype;
        logic [31:0] dip;
        logic [15:0] dport;
        logic [15:0] ulen;
        int          pay_sent;   // -1: whole frame
        bit          gap;
        bit          flip;
        bit          exp_acc;
        bit          exp_ok;
    } vec_t;

    vec_t        vecs [NV];
    int          n_pass = 0, n_checks = 0;
    logic [7:0]  byte_q[$];
    logic [7:0]  exp_data_q[$];
    bit          exp_done_q[$];
    logic [31:0] last_ip = '0;
    logic [15:0] last_port = '0, last_len = '0;
    bit          len_known = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    task automatic build_frame(input vec_t v, input logic [31:0] sip, input logic [15:0] sport);
        logic [7:0]  f[$];
        logic [47:0] smac = 48'h02_00_00_00_00_01;
        logic [31:0] w = 32'hDEADBEEF;
        logic [31:0] crc;
        logic [15:0] tot;
        int          plen;
        plen = (v.ulen >= 16'd8) ? int'(v.ulen) - 8 : 0;
        tot  = 16'd20 + v.ulen;
        for (int i = 0; i < 6; i++) f.push_back(v.mac[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) f.push_back(smac[47-8*i -: 8]);
        f.push_back(v.etype[15:8]); f.push_back(v.etype[7:0]);
        f.push_back(8'h45); f.push_back(8'h00); f.push_back(tot[15:8]); f.push_back(tot[7:0]);
        f.push_back(8'h00); f.push_back(8'h00); f.push_back(8'h40); f.push_back(8'h00);
        f.push_back(8'h40); f.push_back(8'h11); f.push_back(8'h00); f.push_back(8'h00);
        for (int i = 0; i < 4; i++) f.push_back(sip[31-8*i -: 8]);
        for (int i = 0; i < 4; i++) f.push_back(v.dip[31-8*i -: 8]);
        f.push_back(sport[15:8]); f.push_back(sport[7:0]);
        f.push_back(v.dport[15:8]); f.push_back(v.dport[7:0]);
        f.push_back(v.ulen[15:8]); f.push_back(v.ulen[7:0]);
        f.push_back(8'h00); f.push_back(8'h00);
        for (int i = 0; i < plen; i++) f.push_back((i < 4) ? w[31-8*i -: 8] : 8'(i));
        while (f.size() < 60) f.push_back(8'h00);
        crc = 32'hFFFF_FFFF;
        foreach (f[i]) crc = crc_upd(crc, f[i]);
        crc = ~crc;
        for (int i = 0; i < 4; i++) f.push_back(crc[8*i +: 8]);
        if (v.flip) f[43] = f[43] ^ 8'h10;
        byte_q.delete();
        repeat (7) byte_q.push_back(8'h55);
        byte_q.push_back(8'hD5);
        foreach (f[i]) byte_q.push_back(f[i]);
    endtask

    // Scoreboard entries for an accepted frame; payload starts at byte 50 of byte_q.
    task automatic expect_frame(input vec_t v, input int sent, input logic [31:0] sip, input logic [15:0] sport);
        if (v.exp_acc) begin
            for (int k = 0; k < sent; k++) exp_data_q.push_back(byte_q[50+k]);
            exp_done_q.push_back(v.exp_ok);
            last_ip   = sip;
            last_port = sport;
            len_known = (v.ulen >= 16'd8);
            if (len_known) last_len = v.ulen - 16'd8;
        end
    endtask

    task automatic drive_bytes(input int start, input int n, input bit gap);
        for (int i = start; i < start + n; i++) begin
            i_rx_dv = 1'b1; i_rx_de = 1'b1; i_rx_data = byte_q[i];
            @(posedge clk); #1;
            if (gap) begin
                i_rx_de = 1'b0; i_rx_data = 8'($urandom);
                @(posedge clk); #1;
            end
        end
    endtask

    // dv falls with de still high: that byte must not be consumed.
    task automatic end_frame(input int idle);
        i_rx_dv = 1'b0; i_rx_de = 1'b1; i_rx_data = 8'hA5;
        @(posedge clk); #1;
        i_rx_de = 1'b0;
        repeat (idle) begin @(posedge clk); #1; end
    endtask

    task automatic post_checks(input string tag);
        check({tag, "_left_data"}, 64'(exp_data_q.size()), 64'd0);
        check({tag, "_left_done"}, 64'(exp_done_q.size()), 64'd0);
        exp_data_q.delete();
        exp_done_q.delete();
        check({tag, "_src_ip"}, 64'(o_src_ip), 64'(last_ip));
        check({tag, "_src_port"}, 64'(o_src_port), 64'(last_port));
        if (len_known) check({tag, "_data_len"}, 64'(o_data_len), 64'(last_len));
        check({tag, "_busy"}, 64'(o_busy), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_hdr_outs"}, {o_src_ip, o_src_port, o_data_len}, 64'd0);
        check({tag, "_ctl_outs"}, 64'({o_data_de, o_data, o_pkt_done, o_pkt_ok, o_busy}), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input logic [31:0] sip, input logic [15:0] sport, input int idle);
        int plen, sent, n;
        build_frame(v, sip, sport);
        plen = (v.ulen >= 16'd8) ? int'(v.ulen) - 8 : 0;
        sent = (v.pay_sent < 0) ? plen : v.pay_sent;
        n    = (v.pay_sent < 0) ? byte_q.size() : 50 + sent;
        expect_frame(v, sent, sip, sport);
        drive_bytes(0, n, v.gap);
        end_frame(idle);
    endtask

    always @(negedge clk) begin
        if (o_data_de) begin
            if (exp_data_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_data: got %0h expected no byte", o_data);
            end else check("payload_byte", 64'(o_data), 64'(exp_data_q.pop_front()));
        end
        if (o_pkt_done) begin
            if (exp_done_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got ok=%0b expected no done", o_pkt_ok);
            end else check("pkt_ok", 64'(o_pkt_ok), 64'(exp_done_q.pop_front()));
        end
    end

    initial begin
        vec_t g;
        rst_n = 1'b0; i_rx_dv = 1'b0; i_rx_de = 1'b0; i_rx_data = 8'h00;
        #1 check_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        vecs[0]  = '{LOCAL_MAC,        16'h0800, LOCAL_IP,       16'd8080, 16'd12,  -1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{LOCAL_MAC,        16'h0800, LOCAL_IP,       16'd8081, 16'd12,  -1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{LOCAL_MAC,        16'h0806, LOCAL_IP,       16'd8080, 16'd12,  -1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{48'hFFFFFFFFFFFF, 16'h0800, LOCAL_IP,       16'd8080, 16'd12,  -1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{LOCAL_MAC,        16'h0800, LOCAL_IP,       16'd8080, 16'd108, 50, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{LOCAL_MAC,        16'h0800, LOCAL_IP,       16'd8080, 16'd12,  -1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{LOCAL_MAC,        16'h0800, LOCAL_IP,       16'd8080, 16'd8,   -1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{LOCAL_MAC,        16'h0800, LOCAL_IP,       16'd8080, 16'd4,   -1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{LOCAL_MAC,        16'h0800, LOCAL_IP,       16'd8080, 16'd12,  -1, 1'b0, 1'b1, 1'b1, !CRC_EN};
        vecs[9]  = '{48'h0600AABB0CDE, 16'h0800, LOCAL_IP,       16'd8080, 16'd12,  -1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{LOCAL_MAC,        16'h0800, 32'hC0A80F10,   16'd8080, 16'd12,  -1, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], 32'hC0A8_0F02 + 32'(i), 16'd1234 + 16'(i), 6);
            post_checks($sformatf("vec%0d", i));
        end

        // Back-to-back: dv low for a single cycle between frames.
        g = vecs[0];
        run_vec(g, 32'hC0A8_0F20, 16'd2000, 0);
        run_vec(g, 32'hC0A8_0F21, 16'd2001, 6);
        post_checks("b2b");

        // Reset pulsed two bytes into the payload, released with the frame still running.
        build_frame(g, 32'hC0A8_0F30, 16'd3000);
        exp_data_q.push_back(byte_q[50]);
        exp_data_q.push_back(byte_q[51]);
        drive_bytes(0, 52, 1'b0);
        i_rx_de = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 check_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_bytes(52, byte_q.size() - 52, 1'b0);
        end_frame(6);
        last_ip = '0; last_port = '0; last_len = '0; len_known = 1'b1;
        post_checks("after_rst");
        run_vec(g, 32'hC0A8_0F31, 16'd3001, 6);
        post_checks("fresh");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/udp_rx_parser.md
# udp_rx_parser

Receive-side counterpart of the UDP transmit path. Consumes the byte stream assembled from the RMII receive dibits, which still carries the preamble, SFD and FCS. Locates the SFD and parses the Ethernet II, IPv4 (IHL=5) and UDP headers. Filters on local MAC/IP/port, streams the UDP payload bytes out, and reports per-packet status on frame end.

## Interface
Parameters:
- LOCAL_MAC, 48'h06_00_AA_BB_0C_DD: accepted destination MAC; 48'hFFFF_FFFF_FFFF is also always accepted.
- LOCAL_IP, 32'hC0A8_0F0F: accepted IPv4 destination (192.168.15.15).
- LOCAL_PORT, 16'd8080: accepted UDP destination port.

Ports:
- clk  input  1: byte-stream clock.
- rst_n  input  1: reset, asynchronous, active-low.
- i_rx_dv  input  1: frame active; high from first preamble byte through the last FCS byte.
- i_rx_de  input  1: i_rx_data valid this cycle; only meaningful while i_rx_dv=1.
- i_rx_data  input  8: received byte.
- o_data_de  output  1: payload byte valid.
- o_data  output  8: payload byte.
- o_data_len  output  16: UDP length minus 8; valid from the first o_data_de until the next SFD.
- o_src_ip  output  32: source IPv4 address of the current packet.
- o_src_port  output  16: source UDP port of the current packet.
- o_pkt_done  output  1: one-cycle pulse marking the end of an accepted packet.
- o_pkt_ok  output  1: qualifies o_pkt_done; 1 means the packet is good.
- o_busy  output  1: high while in any state other than IDLE.

## Operation
States and transitions:
- IDLE: on a byte 8'h55 → PREAMBLE.
- PREAMBLE: on 8'hD5 → ETH_HDR. On 8'h55, stay. On any other byte → DROP.
- ETH_HDR: 14 bytes. Destination MAC must match LOCAL_MAC or broadcast. Ethertype must be 16'h0800. Otherwise → DROP.
- IP_HDR: 20 bytes. Byte 0 must be 8'h45. Protocol (byte 9) must be 8'h11. Destination IP (bytes 16–19) must equal LOCAL_IP. Otherwise → DROP. Source IP (bytes 12–15) is captured into o_src_ip. The IP checksum is not verified.
- UDP_HDR: 8 bytes. Destination port must equal LOCAL_PORT, otherwise → DROP. UDP length <8 marks the packet bad, then → TAIL. Source port is captured into o_src_port. o_data_len = udp_len − 8.
- PAYLOAD: emits exactly o_data_len bytes, then → TAIL. When o_data_len = 0, PAYLOAD is skipped.
- TAIL: consumes padding and FCS without emitting anything.
- DROP: consumes the rest of the frame silently. No o_pkt_done is produced.

General rules:
- Any state returns to IDLE when i_rx_dv falls.
- The byte counter is 11 bits and counts i_rx_de bytes within the current state. Cycles with i_rx_de=0 are ignored.
- A packet is "accepted" once it passes the UDP_HDR port check.
- For an accepted packet, the frame end (i_rx_dv falling) produces o_pkt_done.
- o_pkt_ok = 0 if any of the following holds:
  - udp_len < 8;
  - fewer than o_data_len payload bytes arrived before i_rx_dv fell;
  - CRC check fails (when enabled).
- A frame that ends before the port check is a silent drop.
- Downstream is responsible for discarding payload bytes of a packet whose o_pkt_ok = 0.

## Timing
- Reset value of all outputs is 0, and state is IDLE.
- o_data_de/o_data are registered: a payload byte that arrives at edge N appears after edge N+1, giving 1-cycle latency.
- o_pkt_done/o_pkt_ok assert for exactly one cycle, on the cycle after i_rx_dv is sampled low.
- i_rx_dv may rise again on that same cycle. A new frame starting with i_rx_dv=1 and byte 8'h55 is parsed normally.
- o_src_ip, o_src_port and o_data_len hold their values until they are overwritten by the next accepted header.
- When i_rx_dv falls and i_rx_de is high in the same cycle, that byte is not consumed.
- An rst_n assertion mid-frame clears everything immediately and produces no o_pkt_done. After reset release the parser resumes at IDLE. If the release happens mid-frame, the remaining bytes cannot form 55…D5 and are discarded.

## Configuration
- Macro UDP_RX_CRC_CHECK_EN.
- Defined:
  - A reflected CRC-32 (poly 32'hEDB88320, init 32'hFFFF_FFFF, no final XOR) runs over every byte from the destination MAC through the last FCS byte.
  - On frame end, o_pkt_ok requires the CRC register to equal 32'hDEBB20E3.
  - The CRC adds no latency to o_pkt_done.
- Undefined: no CRC logic is built, and FCS bytes are ignored.

## Test plan
- **Good packet.** Stimulus: 7×55, D5, dst=LOCAL_MAC, 0800, IPv4 45 to 192.168.15.15 from 192.168.15.2, UDP 1234→8080, len 12, payload DE AD BE EF, pad to 60 bytes, correct FCS. Required response: four o_data_de bytes DE,AD,BE,EF; o_data_len=4; o_src_ip=C0A80F02; o_src_port=1234; o_pkt_done with o_pkt_ok=1.
- **Filtering.** Stimulus: the same frame with dst port 8081, then with ethertype 0806, then with dst MAC broadcast. Required response: the first two produce no o_data_de and no o_pkt_done; the broadcast one is accepted.
- **Truncation.** Stimulus: UDP len 108, but i_rx_dv falls after 50 payload bytes. Required response: 50 bytes emitted, o_pkt_done with o_pkt_ok=0.
- **Gapped input.** Stimulus: the good packet with i_rx_de low on every other cycle; separately, one with UDP len 8. Required response: output identical to the good-packet case; the len-8 packet gives zero o_data_de and o_pkt_ok=1.
- **CRC (with UDP_RX_CRC_CHECK_EN).** Stimulus: the good packet with one payload bit flipped. Required response: o_pkt_ok=0. Without the macro: o_pkt_ok=1.
- **Reset mid-frame.** Stimulus: rst_n pulsed low during PAYLOAD, followed by a fresh good frame. Required response: all outputs 0 immediately, no done pulse, then the second frame is parsed correctly.
